// File: rtl/qft_shot_sampler_if.sv
// Job, shot-stream and histogram handshake bundle for the shot sampler.
interface qft_shot_sampler_if #(
  parameter int unsigned TOTAL_BITS = 8,
  parameter int unsigned SHOT_BITS  = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [4*TOTAL_BITS-1:0]   mag_sq_in;
  logic [SHOT_BITS-1:0]      num_shots;
  logic                      shot_valid;
  logic [1:0]                shot_idx;
  logic                      out_valid;
  logic                      out_ready;
  logic [4*SHOT_BITS-1:0]    hist_out;
  logic                      zero_err;

  modport master (
    output in_valid, mag_sq_in, num_shots, out_ready,
    input  in_ready, shot_valid, shot_idx, out_valid, hist_out, zero_err
  );

  modport slave (
    input  in_valid, mag_sq_in, num_shots, out_ready,
    output in_ready, shot_valid, shot_idx, out_valid, hist_out, zero_err
  );
endinterface

// File: rtl/qft_shot_sampler.sv
// Emulates projective measurement of a 2-qubit state: LFSR-driven sampling by
// cumulative weight, streaming each shot and returning a per-state histogram.
module qft_shot_sampler #(
  parameter int unsigned TOTAL_BITS = 8,
  parameter int unsigned SHOT_BITS  = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input logic               clk,
  input logic               rst_n,
  qft_shot_sampler_if.slave bus
);
  localparam int unsigned WW = TOTAL_BITS - 1;  // clamped weight width
  localparam int unsigned SW = TOTAL_BITS + 1;  // cumulative sum width
  localparam int unsigned PW = 16 + SW;         // lfsr * total product width

  typedef enum logic [1:0] {StIdle, StLoad, StDraw, StDone} state_e;

  state_e                  state_q, state_d;
  logic [4*TOTAL_BITS-1:0] mag_q, mag_d;
  logic [SHOT_BITS-1:0]    nshots_q, nshots_d;
  logic [SHOT_BITS-1:0]    cnt_q, cnt_d;
  logic [SHOT_BITS-1:0]    bin_q [4];
  logic [SHOT_BITS-1:0]    bin_d [4];
  logic [15:0]             lfsr_q, lfsr_d;
  logic                    shot_valid_q, shot_valid_d;
  logic [1:0]              shot_idx_q, shot_idx_d;
  logic                    zero_err_q, zero_err_d;
  logic [SW-1:0]           c0_q, c1_q, c2_q, total_q;
  logic [SW-1:0]           c0_d, c1_d, c2_d, total_d;

  logic [WW-1:0]           w [4];
  logic [SW-1:0]           s0, s1, s2, s3;
  logic [SW-1:0]           r;
  logic [1:0]              idx;

  // Negative weights contribute nothing; index 0 (|00>) lives in the MSBs.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w[i] = mag_q[(3-i)*TOTAL_BITS + TOTAL_BITS - 1] ? '0 : mag_q[(3-i)*TOTAL_BITS +: WW];
    end
    s0 = SW'(w[0]);
    s1 = s0 + SW'(w[1]);
    s2 = s1 + SW'(w[2]);
    s3 = s2 + SW'(w[3]);
  end

  // r lands in [0, total); strict compares never pick a zero-weight state.
  always_comb begin
    r = SW'((PW'(lfsr_q) * PW'(total_q)) >> 16);
    if (r < c0_q)      idx = 2'd0;
    else if (r < c1_q) idx = 2'd1;
    else if (r < c2_q) idx = 2'd2;
    else               idx = 2'd3;
  end

  always_comb begin
    state_d      = state_q;
    mag_d        = mag_q;
    nshots_d     = nshots_q;
    cnt_d        = cnt_q;
    bin_d        = bin_q;
    lfsr_d       = lfsr_q;
    shot_valid_d = 1'b0;
    shot_idx_d   = shot_idx_q;
    zero_err_d   = zero_err_q;
    c0_d         = c0_q;
    c1_d         = c1_q;
    c2_d         = c2_q;
    total_d      = total_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          mag_d      = bus.mag_sq_in;
          nshots_d   = bus.num_shots;
          cnt_d      = '0;
          zero_err_d = 1'b0;
          for (int i = 0; i < 4; i++) bin_d[i] = '0;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        c0_d    = s0;
        c1_d    = s1;
        c2_d    = s2;
        total_d = s3;
        if (s3 == '0) begin
          zero_err_d = 1'b1;
          state_d    = StDone;
        end else if (nshots_q == '0) begin
          state_d = StDone;
        end else begin
          state_d = StDraw;
        end
      end
      StDraw: begin
        bin_d[idx]   = bin_q[idx] + 1'b1;
        shot_valid_d = 1'b1;
        shot_idx_d   = idx;
        cnt_d        = cnt_q + 1'b1;
        lfsr_d       = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        if (cnt_d == nshots_q) state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mag_q        <= '0;
      nshots_q     <= '0;
      cnt_q        <= '0;
      for (int i = 0; i < 4; i++) bin_q[i] <= '0;
      lfsr_q       <= LFSR_SEED;
      shot_valid_q <= 1'b0;
      shot_idx_q   <= 2'd0;
      zero_err_q   <= 1'b0;
      c0_q         <= '0;
      c1_q         <= '0;
      c2_q         <= '0;
      total_q      <= '0;
    end else begin
      state_q      <= state_d;
      mag_q        <= mag_d;
      nshots_q     <= nshots_d;
      cnt_q        <= cnt_d;
      for (int i = 0; i < 4; i++) bin_q[i] <= bin_d[i];
      lfsr_q       <= lfsr_d;
      shot_valid_q <= shot_valid_d;
      shot_idx_q   <= shot_idx_d;
      zero_err_q   <= zero_err_d;
      c0_q         <= c0_d;
      c1_q         <= c1_d;
      c2_q         <= c2_d;
      total_q      <= total_d;
    end
  end

  assign bus.in_ready   = (state_q == StIdle);
  assign bus.out_valid  = (state_q == StDone);
  assign bus.shot_valid = shot_valid_q;
  assign bus.shot_idx   = shot_idx_q;
  assign bus.zero_err   = zero_err_q;
  assign bus.hist_out   = {bin_q[0], bin_q[1], bin_q[2], bin_q[3]};
endmodule

// File: tb/tb_qft_shot_sampler.sv
// Directed bench for qft_shot_sampler: vector table of jobs plus stall,
// back-to-back and mid-draw reset sequences, against a small LFSR model.
module tb_qft_shot_sampler;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  qft_shot_sampler_if #(.TOTAL_BITS(8), .SHOT_BITS(8)) bus ();

  qft_shot_sampler #(
    .TOTAL_BITS(8),
    .SHOT_BITS (8),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] mag;
    logic [7:0]  n;
    logic        zero;
    int          lat;
    logic [31:0] hist;  // exact expectation when kind == 0
    int          kind;  // 0 exact hist, 1 uniform range, 2 bins 1/3 empty, 3 model only
  } vec_t;

  int          total_cnt = 0;
  int          bad_cnt   = 0;
  logic [15:0] lfsr_m;
  vec_t        vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [1:0] model_pick(input logic [31:0] mag, input logic [15:0] l);
    int unsigned c [4];
    int unsigned acc;
    int unsigned r;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = mag[8*(3-i) +: 8];
      if (!b[7]) acc += b[6:0];
      c[i] = acc;
    end
    r = (32'(l) * acc) >> 16;
    if (r < c[0]) return 2'd0;
    if (r < c[1]) return 2'd1;
    if (r < c[2]) return 2'd2;
    return 2'd3;
  endfunction

  // Called at a negedge with in_ready expected high; returns at a negedge.
  task automatic run_job(input vec_t v, input int hold, input string tag);
    logic [7:0]  mh [4];
    logic [1:0]  e;
    logic [31:0] h;
    int          lat, shots, seq_bad, lo, hi;
    bit          stable;
    lat = -1;
    shots = 0;
    seq_bad = 0;
    for (int i = 0; i < 4; i++) mh[i] = 8'd0;
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.mag_sq_in = v.mag;
    bus.num_shots = v.n;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.mag_sq_in = 32'h10101010;
    bus.num_shots = 8'd1;
    for (int k = 1; k <= 400; k++) begin
      if (bus.shot_valid === 1'b1) begin
        e = model_pick(v.mag, lfsr_m);
        if (bus.shot_idx !== e) seq_bad++;
        mh[e] = mh[e] + 8'd1;
        lfsr_m = lfsr_step(lfsr_m);
        shots++;
      end
      if (bus.out_valid === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    h = bus.hist_out;
    check({tag, "_latency"}, 64'(lat), 64'(v.lat));
    check({tag, "_shots"}, 64'(shots), 64'(v.zero ? 0 : int'(v.n)));
    check({tag, "_seq_errs"}, 64'(seq_bad), 64'd0);
    check({tag, "_zero_err"}, 64'(bus.zero_err), 64'(v.zero));
    check({tag, "_hist_model"}, 64'(h), 64'({mh[0], mh[1], mh[2], mh[3]}));
    if (v.kind == 0) check({tag, "_hist"}, 64'(h), 64'(v.hist));
    if (v.kind == 1) begin
      lo = 255;
      hi = 0;
      for (int i = 0; i < 4; i++) begin
        if (int'(h[8*(3-i) +: 8]) < lo) lo = int'(h[8*(3-i) +: 8]);
        if (int'(h[8*(3-i) +: 8]) > hi) hi = int'(h[8*(3-i) +: 8]);
      end
      check({tag, "_bins_in_30_70"}, 64'(lo >= 30 && hi <= 70), 64'd1);
      check({tag, "_sum"}, 64'(h[31:24] + h[23:16] + h[15:8] + h[7:0]), 64'(v.n));
    end
    if (v.kind == 2) begin
      check({tag, "_bins13"}, 64'({h[23:16], h[7:0]}), 64'd0);
      check({tag, "_bins02"}, 64'(h[31:24] + h[15:8]), 64'(v.n));
    end
    if (hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (bus.out_valid !== 1'b1 || bus.hist_out !== h || bus.in_ready !== 1'b0 ||
            bus.zero_err !== v.zero) stable = 1'b0;
      end
      check({tag, "_stall_stable"}, 64'(stable), 64'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_idle_after"}, 64'({bus.in_ready, bus.out_valid}), 64'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{mag: 32'h10000000, n: 8'd10,  zero: 1'b0, lat: 12,  hist: 32'h0A000000, kind: 0};
    vecs[1] = '{mag: 32'h04040404, n: 8'd200, zero: 1'b0, lat: 202, hist: 32'h0,        kind: 1};
    vecs[2] = '{mag: 32'h08000800, n: 8'd255, zero: 1'b0, lat: 257, hist: 32'h0,        kind: 2};
    vecs[3] = '{mag: 32'h00000000, n: 8'd5,   zero: 1'b1, lat: 2,   hist: 32'h0,        kind: 0};
    vecs[4] = '{mag: 32'hF0000000, n: 8'd7,   zero: 1'b1, lat: 2,   hist: 32'h0,        kind: 0};
    vecs[5] = '{mag: 32'h04040404, n: 8'd0,   zero: 1'b0, lat: 2,   hist: 32'h0,        kind: 0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.mag_sq_in = 32'h0;
    bus.num_shots = 8'd0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          64'({bus.in_ready, bus.shot_valid, bus.shot_idx, bus.out_valid, bus.zero_err,
               bus.hist_out}),
          64'({1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0}));
    rst_n  = 1'b1;
    lfsr_m = 16'hACE1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_job(vecs[i], 0, $sformatf("vec%0d", i));

    // Stalled DONE, then a job accepted as soon as in_ready returns.
    run_job('{mag: 32'h00100000, n: 8'd3, zero: 1'b0, lat: 5, hist: 32'h00030000, kind: 0},
            20, "stall");
    run_job('{mag: 32'h00000010, n: 8'd2, zero: 1'b0, lat: 4, hist: 32'h00000002, kind: 0},
            0, "b2b");

    // Reset while shot 5 of a 50-shot job is being drawn.
    bus.in_valid  = 1'b1;
    bus.mag_sq_in = 32'h04040404;
    bus.num_shots = 8'd50;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    begin
      int pulses;
      pulses = 0;
      for (int k = 0; k < 20 && pulses < 4; k++) begin
        if (bus.shot_valid === 1'b1) pulses++;
        if (pulses < 4) @(negedge clk);
      end
      check("rst_pulses_before", 64'(pulses), 64'd4);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_draw_outputs",
          64'({bus.in_ready, bus.shot_valid, bus.shot_idx, bus.out_valid, bus.zero_err,
               bus.hist_out}),
          64'({1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0}));
    rst_n  = 1'b1;
    lfsr_m = 16'hACE1;
    @(negedge clk);
    run_job('{mag: 32'h04040404, n: 8'd20, zero: 1'b0, lat: 22, hist: 32'h0, kind: 3},
            0, "after_rst");

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
